cop0_write_sequencer: RTL

COP0_WRITE_SEQUENCER -- requirements
Module: cop0_write_sequencer

---
 rtl/cop0_pkg.sv | 47 ++++
 rtl/cop0_write_filter.sv | 15 +
 rtl/cop0_write_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cop0_pkg.sv
// Shared COP0 definitions: sequencer states, register addresses, fixed write masks.
// EXC_BADVA only exists when COP0_BADVADDR_WRITE_EN is defined.
package cop0_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXC_EPC,
    EXC_CAUSE,
`ifdef COP0_BADVADDR_WRITE_EN
    EXC_BADVA,
`endif
    EXC_STATUS,
    ERET_STATUS
  } seq_state_t;

  localparam logic [4:0]  REG_BADVADDR   = 5'd8;
  localparam logic [4:0]  REG_STATUS     = 5'd12;
  localparam logic [4:0]  REG_CAUSE      = 5'd13;
  localparam logic [4:0]  REG_EPC        = 5'd14;
  localparam logic [4:0]  REG_PRID       = 5'd15;
  localparam logic [2:0]  SEL0           = 3'd0;
  localparam logic [31:0] MASK_FULL      = 32'hFFFF_FFFF;
  localparam logic [31:0] MASK_CAUSE_EXC = 32'h8000_007C;
  localparam logic [31:0] MASK_CAUSE_SW  = 32'h0000_0300;

  typedef struct packed {
    logic [4:0]  rd;
    logic [2:0]  sel;
    logic [31:0] wdata;
    logic [31:0] wmask;
  } cop0_write_t;

  // Software may not touch BadVAddr or PRId, and only the Cause soft-interrupt bits.
  function automatic logic [31:0] mtc0_write_mask(input logic [4:0] rd, input logic [2:0] sel);
    logic [31:0] mask;
    mask = MASK_FULL;
    if (sel == SEL0) begin
      case (rd)
        REG_BADVADDR, REG_PRID: mask = '0;
        REG_CAUSE:              mask = MASK_CAUSE_SW;
        default:                mask = MASK_FULL;
      endcase
    end
    return mask;
  endfunction

endpackage

// File: rtl/cop0_write_filter.sv
// Per-register writable-bit filter applied to MTC0 writes.
module cop0_write_filter
  import cop0_pkg::*;
(
  input  logic [4:0]  rd,
  input  logic [2:0]  sel,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [31:0] wmask
);

  assign wdata = data;
  assign wmask = mtc0_write_mask(rd, sel);

endmodule

// File: rtl/cop0_write_sequencer.sv
// Serialises MTC0, exception-commit and ERET updates onto one registered COP0 write port.
// Optional BadVAddr write on exceptions is enabled by COP0_BADVADDR_WRITE_EN.
module cop0_write_sequencer
  import cop0_pkg::*;
#(
  parameter int STATUS_EXL_BIT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mtc0_valid,
  output logic        mtc0_ready,
  input  logic [4:0]  mtc0_rd,
  input  logic [2:0]  mtc0_sel,
  input  logic [31:0] mtc0_data,
  input  logic        exc_valid,
  output logic        exc_ready,
  input  logic [31:0] exc_pc,
  input  logic [4:0]  exc_code,
  input  logic        exc_bd,
  input  logic [31:0] exc_badva,
  input  logic        exc_badva_valid,
  input  logic        eret_valid,
  output logic        eret_ready,
  input  logic [31:0] status_in,
  output logic        cop0_we,
  output logic [4:0]  cop0_rd,
  output logic [2:0]  cop0_sel,
  output logic [31:0] cop0_wdata,
  output logic [31:0] cop0_wmask,
  output logic        busy,
  output logic        exc_done
);

  localparam logic [31:0] EXL_MASK = 32'h1 << STATUS_EXL_BIT;

  seq_state_t  state;
  cop0_write_t port_q;
  logic [4:0]  lat_code;
  logic        lat_bd;
  logic [31:0] filt_wdata;
  logic [31:0] filt_wmask;

`ifdef COP0_BADVADDR_WRITE_EN
  logic [31:0] lat_badva;
  logic        lat_badva_valid;
`else
  logic unused_badva;
  assign unused_badva = ^{1'b0, exc_badva, exc_badva_valid};
`endif

  function automatic cop0_write_t mk_write(input logic [4:0] rd, input logic [2:0] sel,
                                           input logic [31:0] wdata, input logic [31:0] wmask);
    cop0_write_t w;
    w.rd    = rd;
    w.sel   = sel;
    w.wdata = wdata;
    w.wmask = wmask;
    return w;
  endfunction

  cop0_write_filter u_filter (
    .rd    (mtc0_rd),
    .sel   (mtc0_sel),
    .data  (mtc0_data),
    .wdata (filt_wdata),
    .wmask (filt_wmask)
  );

  assign exc_ready  = (state == IDLE);
  assign eret_ready = exc_ready && !exc_valid;
  assign mtc0_ready = eret_ready && !eret_valid;

  assign cop0_rd    = port_q.rd;
  assign cop0_sel   = port_q.sel;
  assign cop0_wdata = port_q.wdata;
  assign cop0_wmask = port_q.wmask;

  // Each state names the write currently on the port; the next write is registered on the way in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      port_q   <= '0;
      cop0_we  <= 1'b0;
      busy     <= 1'b0;
      exc_done <= 1'b0;
      lat_code <= '0;
      lat_bd   <= 1'b0;
`ifdef COP0_BADVADDR_WRITE_EN
      lat_badva       <= '0;
      lat_badva_valid <= 1'b0;
`endif
    end else begin
      cop0_we  <= 1'b0;
      exc_done <= 1'b0;
      case (state)
        IDLE: begin
          if (exc_valid && exc_ready) begin
            lat_code <= exc_code;
            lat_bd   <= exc_bd;
`ifdef COP0_BADVADDR_WRITE_EN
            lat_badva       <= exc_badva;
            lat_badva_valid <= exc_badva_valid;
`endif
            port_q  <= mk_write(REG_EPC, SEL0, exc_bd ? exc_pc - 32'd4 : exc_pc, MASK_FULL);
            cop0_we <= 1'b1;
            busy    <= 1'b1;
            state   <= EXC_EPC;
          end else if (eret_valid && eret_ready) begin
            port_q  <= mk_write(REG_STATUS, SEL0, 32'h0, EXL_MASK);
            cop0_we <= 1'b1;
            busy    <= 1'b1;
            state   <= ERET_STATUS;
          end else if (mtc0_valid && mtc0_ready) begin
            port_q  <= mk_write(mtc0_rd, mtc0_sel, filt_wdata, filt_wmask);
            cop0_we <= 1'b1;
          end
        end
        EXC_EPC: begin
          port_q  <= mk_write(REG_CAUSE, SEL0, {lat_bd, 24'b0, lat_code, 2'b0}, MASK_CAUSE_EXC);
          cop0_we <= 1'b1;
          state   <= EXC_CAUSE;
        end
        EXC_CAUSE: begin
          cop0_we <= 1'b1;
`ifdef COP0_BADVADDR_WRITE_EN
          if (lat_badva_valid) begin
            port_q <= mk_write(REG_BADVADDR, SEL0, lat_badva, MASK_FULL);
            state  <= EXC_BADVA;
          end else begin
            port_q   <= mk_write(REG_STATUS, SEL0, status_in | EXL_MASK, EXL_MASK);
            exc_done <= 1'b1;
            state    <= EXC_STATUS;
          end
`else
          port_q   <= mk_write(REG_STATUS, SEL0, status_in | EXL_MASK, EXL_MASK);
          exc_done <= 1'b1;
          state    <= EXC_STATUS;
`endif
        end
`ifdef COP0_BADVADDR_WRITE_EN
        EXC_BADVA: begin
          port_q   <= mk_write(REG_STATUS, SEL0, status_in | EXL_MASK, EXL_MASK);
          cop0_we  <= 1'b1;
          exc_done <= 1'b1;
          state    <= EXC_STATUS;
        end
`endif
        EXC_STATUS, ERET_STATUS: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
